inst_fetch: RTL and testbench

//  Instruction fetch unit: the initiator side of the instruction-memory read port.

---
 rtl/inst_fetch.sv | 139 +++++++++++++
 tb/tb_inst_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: drives a word address to inst_mem and queues {pc, word} in a prefetch FIFO for decode.
// Latency: a fetched word is visible to decode one cycle after its fetch edge (no bypass); 1 instr/cycle sustained.
// Backpressure: i_inst_ready low fills the FIFO, then fetch stalls; i_redirect flushes the FIFO and restarts fetch.
//
// Ports: i_clk/i_rst_n (async active-low); o_imem_addr/i_imem_data (combinational memory read);
//        o_inst_valid/o_inst/o_inst_pc/i_inst_ready (decode handshake); i_redirect/i_redirect_pc (flush);
//        o_fetch_stopped only when IFETCH_SYS_STOP_EN is defined (fetch halts after a SYSTEM opcode).
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
`ifdef IFETCH_SYS_STOP_EN
    ,
    output logic        o_fetch_stopped
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // PCs are kept as word addresses: the low two byte-address bits are always zero,
    // and incrementing a 30-bit word PC wraps exactly like a 32-bit byte PC += 4.
    logic [31:2]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:2] pc_mem_q   [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];

    logic have_entry;
    logic full;
    logic fetch_en;
    logic deq;
    logic enq;

    // Redirect PC is word aligned by construction; its byte-offset bits are don't-care.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

`ifdef IFETCH_SYS_STOP_EN
    logic stopped_q, stopped_d;
    assign fetch_en = !stopped_q;
`else
    assign fetch_en = 1'b1;
`endif

    assign have_entry = (cnt_q != '0);
    assign full       = (cnt_q == CNT_W'(DEPTH));

    // Redirect suppresses both sides of the FIFO for the cycle it is asserted.
    assign o_inst_valid = have_entry & !i_redirect;
    assign deq          = o_inst_valid & i_inst_ready;
    assign enq          = !i_redirect & fetch_en & (!full | deq);

    assign o_imem_addr = {2'b00, fetch_pc_q};
    assign o_inst      = have_entry ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign o_inst_pc   = have_entry ? {pc_mem_q[rd_ptr_q], 2'b00} : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc[31:2];
            rd_ptr_d   = wr_ptr_q;
            cnt_d      = '0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc_q + 30'd1;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

`ifdef IFETCH_SYS_STOP_EN
    // Sticky after a SYSTEM word is queued; only a redirect (or reset) resumes fetch.
    always_comb begin
        stopped_d = stopped_q;
        if (i_redirect) begin
            stopped_d = 1'b0;
        end else if (enq && (i_imem_data[6:0] == 7'h73)) begin
            stopped_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stopped_q <= 1'b0;
        end else begin
            stopped_q <= stopped_d;
        end
    end

    assign o_fetch_stopped = stopped_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC[31:2];
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while cnt_q covers them.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= i_imem_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef IFETCH_SYS_STOP_EN
    logic        fetch_stopped;
`endif

    logic [31:0] imem [256];
    exp_t        sb_q [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_imem_addr    (imem_addr),
        .i_imem_data    (imem_data),
        .o_inst_valid   (inst_valid),
        .o_inst         (inst),
        .o_inst_pc      (inst_pc),
        .i_inst_ready   (inst_ready),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc)
`ifdef IFETCH_SYS_STOP_EN
        ,
        .o_fetch_stopped(fetch_stopped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural instruction memory: 256 words, everything else reads as zero.
    assign imem_data = (imem_addr < 32'd256) ? imem[imem_addr[7:0]] : 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: after reset/redirect the decode stream is the words at
    // consecutive PCs from the restart PC (stopping after a SYSTEM word when enabled).
    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        exp_t        e;
        p = pc & 32'hFFFF_FFFC;
        sb_q.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc   = p;
            e.inst = (p[31:10] == 22'd0) ? imem[p[9:2]] : 32'h0;
            sb_q.push_back(e);
`ifdef IFETCH_SYS_STOP_EN
            if (e.inst[6:0] == 7'h73) break;
`endif
            p = p + 32'd4;
        end
    endtask

    // Monitor: every accepted instruction must be the next one the model predicts.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got pc %h inst %h expected no instruction", inst_pc, inst);
            end else begin
                mon_e = sb_q.pop_front();
                check("stream", {inst_pc, inst}, {mon_e.pc, mon_e.inst});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic load_image();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[0] = 32'h00A0_0593;
        imem[1] = 32'h0005_8073;
    endtask

    // Reset with the given ready level; returns just after the release point.
    task automatic do_reset(input logic rdy);
        step();
        rst_n      = 1'b0;
        redirect   = 1'b0;
        inst_ready = rdy;
        sb_restart(32'h0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        step();
        redirect    = 1'b1;
        redirect_pc = pc;
        sb_restart(pc);
    endtask

    initial begin
        int since;
        rst_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        load_image();
        sb_restart(32'h0);
        #2;
        check("rst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_addr", {32'd0, imem_addr}, 64'd0);

        // Latency and throughput from reset with decode always ready.
        do_reset(1'b1);
        sample();
        check("t1_valid_before_edge", {63'd0, inst_valid}, 64'd0);
        step(); sample();
        check("t1_c1", {inst_valid, inst_pc, 31'd0}, {1'b1, 32'h0, 31'd0});
        check("t1_addr1", {32'd0, imem_addr}, 64'd1);
        step(); sample();
        check("t1_c2", {inst_valid, inst_pc, 31'd0}, {1'b1, 32'h4, 31'd0});
`ifndef IFETCH_SYS_STOP_EN
        step(); sample();
        check("t1_c3", {inst_valid, inst_pc, 31'd0}, {1'b1, 32'h8, 31'd0});
        check("t1_addr3", {32'd0, imem_addr}, 64'd3);

        // Fill with decode stalled, then one accept on a full FIFO.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step();
        sample();
        check("t2_addr_full", {32'd0, imem_addr}, 64'd4);
        check("t2_head", {inst_valid, inst_pc, inst[30:0]}, {1'b1, 32'h0, 31'h00A0_0593});
        step(); sample();
        check("t2_addr_held", {32'd0, imem_addr}, 64'd4);
        step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        sample();
        check("t3_addr", {32'd0, imem_addr}, 64'd5);
        check("t3_head", {inst_pc, inst}, {32'h4, 32'h0005_8073});
        check("t3_valid", {63'd0, inst_valid}, 64'd1);
        step();
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            check("t3_no_gap", {63'd0, inst_valid}, 64'd1);
            step();
        end
`else
        // SYSTEM word at pc 0x4 halts fetch after it drains.
        step(); step(); sample();
        check("t6_valid", {63'd0, inst_valid}, 64'd0);
        check("t6_stopped", {63'd0, fetch_stopped}, 64'd1);
        check("t6_addr", {32'd0, imem_addr}, 64'd2);
        step();
`endif

        // Redirect to a misaligned PC: two bubbles, then pc 0x4.
        inst_ready = 1'b1;
        do_redirect(32'h0000_0006);
        sample();
        check("t4_valid_redir", {63'd0, inst_valid}, 64'd0);
        step();
        redirect = 1'b0;
        sample();
        check("t4_valid_next", {63'd0, inst_valid}, 64'd0);
        check("t4_addr", {32'd0, imem_addr}, 64'd1);
        step(); sample();
        check("t4_first", {inst_valid, inst_pc, 31'd0}, {1'b1, 32'h4, 31'd0});

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        step(); sample();
        check("t5_top", {inst_valid, inst_pc, 31'd0}, {1'b1, 32'hFFFF_FFFC, 31'd0});
        step(); sample();
        check("t5_wrap", {inst_valid, inst_pc, 31'd0}, {1'b1, 32'h0, 31'd0});

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_arst_valid", {63'd0, inst_valid}, 64'd0);
        check("t5_arst_inst", {inst_pc, inst}, 64'd0);
        check("t5_arst_addr", {32'd0, imem_addr}, 64'd0);

        // Randomised phase over a random memory image.
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        hs_cnt = 0;
        do_reset(1'b1);
        since = 0;
        for (int c = 0; c < 800; c++) begin
            step();
            inst_ready = ($urandom_range(0, 9) < 7);
            if (since >= 40 || $urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom_range(0, 32'h200);
                sb_restart(redirect_pc);
                since = 0;
            end else begin
                redirect = 1'b0;
                since++;
            end
        end
        step();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        sample();
`ifndef IFETCH_SYS_STOP_EN
        check("rand_handshakes", {63'd0, hs_cnt > 200}, 64'd1);
`else
        check("rand_handshakes", {63'd0, hs_cnt > 20}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
